// File: rtl/envelope_gen.sv
// ADSR envelope generator for one voice: a 16-bit level stepped by sample_tick,
// presented as a non-negative 9-bit signed amplitude for the voice multiplier.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | silent, level held at 0
// ATTACK  | level rising by step(attack) per tick toward 0xFFFF
// DECAY   | level falling by step(decay) per tick toward sustain level
// SUSTAIN | level follows the live sustain code while gate is high
// RELEASE | level falling by step(release) per tick toward 0
module envelope_gen (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_gate,
    input  logic       i_sample_tick,
    input  logic [3:0] i_attack,
    input  logic [3:0] i_decay,
    input  logic [3:0] i_sustain,
    input  logic [3:0] i_release,
    output logic [8:0] o_amplitude,
    output logic [2:0] o_env_state,
    output logic       o_active
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]  r_state;
    logic [15:0] r_level;
    logic        r_gate_q;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_level_nxt;
    logic        w_rise;
    logic        w_fall;
    logic [15:0] w_step_a;
    logic [15:0] w_step_d;
    logic [15:0] w_step_r;
    logic [15:0] w_sus;
    logic [16:0] w_att_sum;
    logic [16:0] w_dec_lim;

    assign w_rise    = i_gate & ~r_gate_q;
    assign w_fall    = ~i_gate & r_gate_q;
    assign w_step_a  = 16'd1 << (4'd15 - i_attack);
    assign w_step_d  = 16'd1 << (4'd15 - i_decay);
    assign w_step_r  = 16'd1 << (4'd15 - i_release);
    assign w_sus     = {4{i_sustain}};
    // 17-bit arithmetic so the attack overshoot and decay limit never wrap
    assign w_att_sum = {1'b0, r_level} + {1'b0, w_step_a};
    assign w_dec_lim = {1'b0, w_sus} + {1'b0, w_step_d};

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state  <= S_IDLE;
            r_level  <= 16'd0;
            r_gate_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_level  <= w_level_nxt;
            r_gate_q <= i_gate;
        end
    end

    // Any gate edge wins the cycle: state may move, level holds, tick is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        if (w_rise) begin
            w_state_nxt = S_ATTACK;
        end else if (w_fall) begin
            if (r_state == S_ATTACK || r_state == S_DECAY || r_state == S_SUSTAIN)
                w_state_nxt = S_RELEASE;
        end else if (i_sample_tick) begin
            case (r_state)
                S_IDLE: w_level_nxt = 16'd0;
                S_ATTACK: begin
                    if (w_att_sum >= 17'h0FFFF) begin
                        w_level_nxt = 16'hFFFF;
                        w_state_nxt = S_DECAY;
                    end else begin
                        w_level_nxt = w_att_sum[15:0];
                    end
                end
                S_DECAY: begin
                    if ({1'b0, r_level} <= w_dec_lim) begin
                        w_level_nxt = w_sus;
                        w_state_nxt = S_SUSTAIN;
                    end else begin
                        w_level_nxt = r_level - w_step_d;
                    end
                end
                S_SUSTAIN: w_level_nxt = w_sus;
                S_RELEASE: begin
                    if (r_level <= w_step_r) begin
                        w_level_nxt = 16'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_level_nxt = r_level - w_step_r;
                    end
                end
                default: begin
                    w_level_nxt = 16'd0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_amplitude = {1'b0, r_level[15:8]};
        o_env_state = r_state;
        o_active    = (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_envelope_gen.sv
// Bench for envelope_gen: directed ADSR scenarios with literal expectations,
// then randomized gate/tick/code stimulus checked every cycle against a model.
module tb_envelope_gen;

    localparam int IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       gate = 1'b0;
    logic       sample_tick = 1'b0;
    logic [3:0] attack = 4'd0, decay = 4'd0, sustain = 4'd0, rel = 4'd0;
    logic [8:0] amplitude;
    logic [2:0] env_state;
    logic       active;

    int vectors = 0;
    int miscompares = 0;

    int m_level = 0;
    int m_state = IDLE;
    bit m_gate_q = 1'b0;

    envelope_gen dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_gate        (gate),
        .i_sample_tick (sample_tick),
        .i_attack      (attack),
        .i_decay       (decay),
        .i_sustain     (sustain),
        .i_release     (rel),
        .o_amplitude   (amplitude),
        .o_env_state   (env_state),
        .o_active      (active)
    );

    always #5 clk = ~clk;

    function automatic int step_of(input logic [3:0] code);
        return 1 << (15 - int'(code));
    endfunction

    // Reference envelope: plain integer arithmetic on the documented rules.
    always @(posedge clk) begin
        if (!resetn) begin
            m_level  = 0;
            m_state  = IDLE;
            m_gate_q = 1'b0;
        end else begin
            int sus;
            sus = 16'(int'(sustain) * 'h1111);
            if (gate && !m_gate_q) begin
                m_state = ATTACK;
            end else if (!gate && m_gate_q) begin
                if (m_state == ATTACK || m_state == DECAY || m_state == SUSTAIN)
                    m_state = RELEASE;
            end else if (sample_tick) begin
                if (m_state == IDLE) begin
                    m_level = 0;
                end else if (m_state == ATTACK) begin
                    if (m_level + step_of(attack) >= 65535) begin
                        m_level = 65535;
                        m_state = DECAY;
                    end else m_level = m_level + step_of(attack);
                end else if (m_state == DECAY) begin
                    if (m_level <= sus + step_of(decay)) begin
                        m_level = sus;
                        m_state = SUSTAIN;
                    end else m_level = m_level - step_of(decay);
                end else if (m_state == SUSTAIN) begin
                    m_level = sus;
                end else begin
                    if (m_level <= step_of(rel)) begin
                        m_level = 0;
                        m_state = IDLE;
                    end else m_level = m_level - step_of(rel);
                end
            end
            m_gate_q = gate;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        check("amplitude", int'(amplitude), m_level >> 8);
        check("env_state", int'(env_state), m_state);
        check("active", int'(active), (m_state != IDLE) ? 1 : 0);
    end

    task automatic cyc(input bit t);
        sample_tick = t;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    initial begin
        attack = 4'd0; decay = 4'd0; sustain = 4'd8; rel = 4'd0;

        // Reset held with gate and tick asserted
        resetn = 1'b0; gate = 1'b1; sample_tick = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("rst_amp", int'(amplitude), 0);
            check("rst_state", int'(env_state), IDLE);
            check("rst_active", int'(active), 0);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rel_state", int'(env_state), ATTACK);
        check("rel_amp", int'(amplitude), 0);

        // Attack/decay into sustain with fastest rates
        cyc(1); check("att_t1_amp", int'(amplitude), 128);
        cyc(1); check("att_t2_amp", int'(amplitude), 255);
        check("att_t2_state", int'(env_state), DECAY);
        cyc(1); check("dec_amp", int'(amplitude), 136);
        check("dec_model_lvl", m_level, 'h8888);
        check("dec_state", int'(env_state), SUSTAIN);

        // Release
        gate = 1'b0;
        cyc(0); check("relE_state", int'(env_state), RELEASE);
        check("relE_amp", int'(amplitude), 136);
        cyc(1); check("relT1_amp", int'(amplitude), 8);
        cyc(1); check("relT2_amp", int'(amplitude), 0);
        check("relT2_state", int'(env_state), IDLE);
        check("relT2_active", int'(active), 0);

        // Retrigger from a slow release
        gate = 1'b1; cyc(0);
        repeat (3) cyc(1);
        check("rt_sus_state", int'(env_state), SUSTAIN);
        rel = 4'd15; gate = 1'b0; cyc(0);
        repeat (16) cyc(1);
        check("rt_model_lvl", m_level, 'h8878);
        check("rt_amp", int'(amplitude), 'h88);
        attack = 4'd15; gate = 1'b1; cyc(0);
        check("rt_state", int'(env_state), ATTACK);
        check("rt_hold_lvl", m_level, 'h8878);
        cyc(1);
        check("rt_step_lvl", m_level, 'h8879);
        check("rt_step_amp", int'(amplitude), 'h88);

        // Gate edge coinciding with a tick
        resetn = 1'b0; gate = 1'b0; cyc(0); resetn = 1'b1;
        attack = 4'd0; gate = 1'b1; cyc(0); cyc(1);
        check("coin_pre_amp", int'(amplitude), 128);
        gate = 1'b0; cyc(1);
        check("coin_state", int'(env_state), RELEASE);
        check("coin_amp", int'(amplitude), 128);
        check("coin_model_lvl", m_level, 'h8000);

        // Zero sustain: decay settles at 0 but stays in SUSTAIN
        gate = 1'b1; cyc(0); cyc(1);
        check("z_top_amp", int'(amplitude), 255);
        sustain = 4'd0; decay = 4'd0;
        cyc(1); check("z_mid_lvl", m_level, 'h7FFF);
        cyc(1);
        check("z_amp", int'(amplitude), 0);
        check("z_state", int'(env_state), SUSTAIN);
        check("z_active", int'(active), 1);
        repeat (10) cyc(1);
        check("z_hold_state", int'(env_state), SUSTAIN);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) gate = ~gate;
            if ($urandom_range(0, 99) < 2) attack  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2) decay   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2) sustain = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2) rel     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 10) begin
                attack = 4'($urandom_range(0, 5));
                decay  = 4'($urandom_range(0, 5));
                rel    = 4'($urandom_range(0, 5));
            end
            resetn = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            cyc(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        end
        resetn = 1'b1;
        cyc(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
